// File: rtl/dl_pkg.sv
// dl_pkg: shared types and lane constants for the SDRAM download writer
package dl_pkg;
  typedef struct packed {
    logic [23:1] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } dl_entry_t;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;
  localparam logic [1:0] DS_W  = 2'b11;
endpackage

// File: rtl/sdram_dl_writer_if.sv
// sdram_dl_writer_if: toggle-handshake write port towards one SDRAM controller port
interface sdram_dl_writer_if;
  logic        req;
  logic        ack;
  logic        we;
  logic [23:1] a;
  logic [1:0]  ds;
  logic [15:0] d;
  modport master (output req, we, a, ds, d, input ack);
  modport slave  (input req, we, a, ds, d, output ack);
endinterface

// File: rtl/dl_fifo.sv
// dl_fifo: first-word-fall-through FIFO of write entries; a push into a full FIFO succeeds only with a same-cycle pop
module dl_fifo
  import dl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      wr,
  input  dl_entry_t wdata,
  input  logic      rd,
  output dl_entry_t rdata,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);
  dl_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  always_comb begin
    full  = count == (AW+1)'(DEPTH);
    empty = count == '0;
    do_rd = rd && !empty;
    do_wr = wr && (!full || do_rd);
    rdata = mem[rp];
  end
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(do_wr);
      rp    <= rp + AW'(do_rd);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/sdram_dl_writer.sv
// sdram_dl_writer: pairs ioctl download bytes into 16-bit SDRAM writes issued over a req/ack toggle port
module sdram_dl_writer
  import dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [22:0] BASE_ADDR  = 23'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        overflow,
  output logic        done,
  sdram_dl_writer_if.master mem
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic pend_v, hold_v, downl_r, active, ack_r;
  logic [23:1] pend_a, wa, pn_a;
  logic [7:0] pend_b, pn_b;
  dl_entry_t hold_e, lo_p, hi_e, sa_e, fl_e, push_e, hold_ne, head;
  logic even, s, match, sa_v, sb_v, pn_v, fall, fl_v, push_v, hold_nv, pop, fin;
  logic full, empty;
  logic [AW:0] count;
  state_t state;
  // At most one FIFO push per cycle: order is hold, strobe entries, then the end-of-download flush;
  // whichever second entry arises is parked in the hold register.
  always_comb begin
    wa      = BASE_ADDR + {2'b00, ioctl_addr[21:1]};
    even    = !ioctl_addr[0];
    s       = ioctl_wr && !hold_v;
    match   = pend_v && pend_a == wa;
    lo_p    = {pend_a, DS_LO, 8'h00, pend_b};
    hi_e    = {wa, DS_HI, ioctl_dout, 8'h00};
    sa_v    = s && (!even || pend_v);
    sa_e    = pend_v && (even || !match) ? lo_p : match ? dl_entry_t'({wa, DS_W, ioctl_dout, pend_b}) : hi_e;
    sb_v    = s && !even && pend_v && !match;
    pn_v    = s ? even : pend_v;
    pn_a    = s && even ? wa : pend_a;
    pn_b    = s && even ? ioctl_dout : pend_b;
    fall    = downl_r && !ioctl_downl;
    fl_v    = fall && pn_v;
    fl_e    = {pn_a, DS_LO, 8'h00, pn_b};
    push_v  = hold_v || sa_v || fl_v;
    push_e  = hold_v ? hold_e : sa_v ? sa_e : fl_e;
    hold_nv = sb_v || ((hold_v || sa_v) && fl_v);
    hold_ne = sb_v ? hi_e : fl_e;
    pop     = state == ST_IDLE && !empty;
    fin     = !ioctl_downl && active && empty && !pend_v && !hold_v && !push_v && state == ST_IDLE;
    ioctl_wait = count >= (AW+1)'(FIFO_DEPTH - 1) || hold_v;
  end
  dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push_v),
    .wdata (push_e),
    .rd    (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v   <= 1'b0;
      pend_a   <= '0;
      pend_b   <= '0;
      hold_v   <= 1'b0;
      hold_e   <= '0;
      downl_r  <= 1'b0;
      active   <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      ack_r    <= mem.ack;
      mem.req  <= mem.ack;
      mem.we   <= 1'b0;
      mem.a    <= '0;
      mem.ds   <= '0;
      mem.d    <= '0;
      state    <= ST_IDLE;
    end else begin
      pend_v   <= pn_v && !fall;
      pend_a   <= pn_a;
      pend_b   <= pn_b;
      hold_v   <= hold_nv;
      hold_e   <= hold_ne;
      downl_r  <= ioctl_downl;
      ack_r    <= mem.ack;
      overflow <= overflow || (push_v && full && !pop) || (ioctl_wr && hold_v);
      done     <= fin;
      active   <= ioctl_downl || (active && !fin);
      if (state == ST_IDLE) begin
        if (!empty) begin
          mem.a   <= head.a;
          mem.ds  <= head.ds;
          mem.d   <= head.d;
          mem.we  <= 1'b1;
          mem.req <= ~mem.req;
          state   <= ST_BUSY;
        end
      end else if (ack_r == mem.req) begin
        mem.we <= 1'b0;
        state  <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sdram_dl_writer.sv
// tb_sdram_dl_writer: directed checks of byte pairing, stalls, back-pressure, done and reset behaviour
module tb_sdram_dl_writer;
  logic clk = 1'b0;
  logic reset, ioctl_downl, ioctl_wr;
  logic [21:0] ioctl_addr;
  logic [7:0] ioctl_dout;
  logic ioctl_wait, overflow, done;
  int n_cmp = 0;
  int n_err = 0;
  sdram_dl_writer_if bus ();
  sdram_dl_writer #(.FIFO_DEPTH(4), .BASE_ADDR(23'h000000)) dut (
    .clk         (clk),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wait  (ioctl_wait),
    .overflow    (overflow),
    .done        (done),
    .mem         (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [21:0] ad, input logic [7:0] dt);
    ioctl_addr = ad;
    ioctl_dout = dt;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask
  task automatic serve(input string tag, input logic [22:0] ea, input logic [1:0] eds, input logic [15:0] ed);
    int n = 0;
    while (bus.req === bus.ack && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 48'(bus.req !== bus.ack), 48'd1);
    chk({tag, "_ent"}, {bus.we, bus.a, bus.ds, bus.d}, {1'b1, ea, eds, ed});
    repeat (5) tick();
    chk({tag, "_stable"}, {bus.we, bus.a, bus.ds, bus.d}, {1'b1, ea, eds, ed});
    bus.ack = bus.req;
    n = 0;
    while (bus.we !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 48'(bus.we), 48'd0);
  endtask
  initial begin
    reset = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    bus.ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_out", {bus.req, bus.we, bus.a, bus.ds, bus.d}, 48'd0);
    chk("rst_flags", {45'd0, ioctl_wait, overflow, done}, 48'd0);
    // merged even/odd pair
    ioctl_downl = 1'b1;
    tick();
    send(22'd0, 8'h11);
    send(22'd1, 8'h22);
    chk("merge_lat", 48'(bus.req), 48'd0);
    tick();
    chk("merge_tog", 48'(bus.req), 48'd1);
    serve("merge", 23'd0, 2'b11, 16'h2211);
    tick();
    chk("merge_once", {bus.req, bus.ack}, 48'b11);
    // lone even byte flushed at end of download, then done
    send(22'd4, 8'hAA);
    ioctl_downl = 1'b0;
    tick();
    serve("lone_even", 23'd2, 2'b01, 16'h00AA);
    tick();
    chk("done_pulse", 48'(done), 48'd1);
    tick();
    chk("done_clr", 48'(done), 48'd0);
    // lone odd byte
    ioctl_downl = 1'b1;
    tick();
    send(22'd7, 8'hBB);
    serve("lone_odd", 23'd3, 2'b10, 16'hBB00);
    // address jump and odd mismatch stall
    send(22'd8, 8'h01);
    send(22'd20, 8'h02);
    send(22'd31, 8'h03);
    chk("stall_wait", 48'(ioctl_wait), 48'd1);
    tick();
    chk("stall_rel", 48'(ioctl_wait), 48'd0);
    serve("jump0", 23'd4, 2'b01, 16'h0001);
    serve("jump1", 23'd10, 2'b01, 16'h0002);
    serve("jump2", 23'd15, 2'b10, 16'h0300);
    chk("no_ovf", 48'(overflow), 48'd0);
    // back-pressure with ack held
    send(22'd41, 8'hA1);
    send(22'd43, 8'hA2);
    send(22'd45, 8'hA3);
    chk("bp_wait_lo", 48'(ioctl_wait), 48'd0);
    send(22'd47, 8'hA4);
    chk("bp_wait_hi", 48'(ioctl_wait), 48'd1);
    send(22'd49, 8'hA5);
    chk("bp_full_ovf", 48'(overflow), 48'd0);
    send(22'd51, 8'hA6);
    chk("bp_ovf", 48'(overflow), 48'd1);
    serve("drain0", 23'd20, 2'b10, 16'hA100);
    serve("drain1", 23'd21, 2'b10, 16'hA200);
    serve("drain2", 23'd22, 2'b10, 16'hA300);
    serve("drain3", 23'd23, 2'b10, 16'hA400);
    serve("drain4", 23'd24, 2'b10, 16'hA500);
    repeat (3) tick();
    chk("drain_idle", {bus.we, bus.req ^ bus.ack, ioctl_wait, overflow}, 48'b0001);
    // reset while a request is outstanding
    send(22'd61, 8'h5B);
    tick();
    chk("busy_pre", 48'(bus.req !== bus.ack), 48'd1);
    reset = 1'b1;
    ioctl_downl = 1'b0;
    tick();
    reset = 1'b0;
    chk("rstb_sync", {bus.req ^ bus.ack, bus.we, overflow, done}, 48'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstb_quiet", {bus.req ^ bus.ack, bus.we, done, ioctl_wait}, 48'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_dl_writer.md
# sdram_dl_writer

Bridges the byte-wide ROM/data download stream from the MiST data_io block into one toggle-handshake request port of the bank-interleaved SDRAM controller (port1 or port2). It merges consecutive even/odd bytes into 16-bit word writes, buffers them in a small FIFO, and issues one write per request/acknowledge toggle. Back-pressure to the download source is provided through `ioctl_wait`.

## Interface

Parameters:
- FIFO_DEPTH, 4: write-entry FIFO depth; must be a power of two and at least 2.
- BASE_ADDR, 23'h000000: word offset added to every download word address.

Ports:
- clk  in  1  SDRAM clock, the same clock as the SDRAM controller.
- reset  in  1  synchronous, active-high.
- ioctl_downl  in  1  download in progress.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  22  byte address within the download.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure; the source must not strobe while it is high.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- done  out  1  one-cycle pulse when a download has fully reached SDRAM.
- req  out  1  request toggle to the controller port.
- ack  in  1  acknowledge toggle from the controller port.
- we  out  1  always 1 while a request is outstanding, 0 otherwise.
- a  out  23  word address [23:1].
- ds  out  2  byte enables; ds[1] enables d[15:8], ds[0] enables d[7:0].
- d  out  16  write data.

## Operation

- Byte lanes: an even byte address goes to d[7:0], an odd byte address goes to d[15:8].
- Word address = BASE_ADDR + ioctl_addr[21:1], truncated to 23 bits.
- Pairing register (`pend_v`, `pend_a`, `pend_b`) holds one unmatched even byte.
- Even byte, no pending byte: store it in pending.
- Even byte while a pending byte exists: push the old pending as {pend_a, ds=01, d={8'h00, pend_b}}, then store the new byte in pending.
- Odd byte with matching pending word address: push {a, ds=11, d={byte, pend_b}} and clear pending.
- Odd byte, no pending or pending address differs: push any pending with ds=01 first, then push {a, ds=10, d={byte, 8'h00}}.
- At most one push per cycle is allowed. A case that needs two pushes (flush plus new entry) stalls the second push one cycle in an internal hold register. `ioctl_wait` covers this stall.
- Falling edge of ioctl_downl with pending valid: push pending with ds=01.
- FIFO full on a required push: the entry is dropped, `overflow` is set, and it clears only on reset.
- `ioctl_wait` = (FIFO count >= FIFO_DEPTH-1) or hold register occupied.
- Handshake FSM:
  - IDLE: if the FIFO is non-empty, pop the head, register a/ds/d, set we=1, toggle req, go to BUSY.
  - BUSY: when ack == req, set we=0 and go to IDLE.
  - a/ds/d/we must stay stable for the whole time req != ack.
- `done` pulses when all of the following hold: ioctl_downl is low, a download was active since the last done, the FIFO is empty, pending is clear, the hold register is empty, and the FSM is in IDLE.

## Timing

- Reset values: req <= ack (no spurious request), we=0, a=0, ds=00, d=0, ioctl_wait=0, overflow=0, done=0.
- Reset also clears the FIFO, pending, hold, and the download-active flag, and puts the FSM in IDLE.
- Reset during BUSY abandons the outstanding request. req resynchronises to ack.
- Latency: a merged odd byte is strobed at cycle N. The FIFO write happens at N+1. req toggles at N+2 if the FSM is IDLE and the FIFO was empty.
- The controller acknowledges a write at its CAS slot, 3–14 clk after the toggle. Steady-state throughput is one word per controller cycle.
- Simultaneous FIFO push and pop: both take effect and the count is unchanged. A push into a full FIFO with a same-cycle pop is accepted.
- ack is sampled registered and compared only in BUSY. An ack change seen in IDLE is ignored.
- A push and the ioctl_downl falling-edge flush in the same cycle: the strobe entry first, the flush next cycle through the hold register.

## Structure

- Package `dl_pkg`:
  - `dl_entry_t` struct {a[23:1], ds[1:0], d[15:0]}.
  - FSM state enum {ST_IDLE, ST_BUSY}.
  - Lane constants DS_LO=2'b01, DS_HI=2'b10, DS_W=2'b11.
- Sub-module `dl_fifo`: synchronous FIFO of dl_entry_t, parameter DEPTH, with full/empty/count outputs and first-word-fall-through head.
- Top level contains the pairing logic, the hold register, the handshake FSM, and the done/overflow logic.

## Test plan

- Merged write: bytes 0x11@0, 0x22@1, with ack echoed 5 clk after each toggle -> one request with a=0, ds=11, d=16'h2211, req toggles once.
- Lone even byte then end: byte 0xAA@4, ioctl_downl falls -> one write with a=2, ds=01, d=16'h00AA, then a done pulse.
- Lone odd byte: 0xBB@7 -> a=3, ds=10, d=16'hBB00.
- Address jump: 0x01@8 then 0x02@20 -> first write a=4, ds=01, d=16'h0001, second a=10 pending until flush. ioctl_wait rises during the stall cycle.
- Back-pressure: ack held constant and bytes strobed while ioctl_wait is ignored -> ioctl_wait high at count 3 (DEPTH 4); the byte strobed with the FIFO full is dropped and sets overflow=1. Releasing ack drains the entries in order.
- Reset in BUSY: reset while req != ack -> next cycle req == ack, we=0, FIFO empty, no done pulse.
